// File: rtl/fib_pkg.sv
// Shared parameters for the Fibonacci term stream buffer.
// Holds the default width, term limit and counter-width helper.
package fib_pkg;

    localparam int FIB_W       = 32;
    localparam int FIB_N_TERMS = 99;

    function automatic int cnt_width(input int n_terms);
        return $clog2(n_terms + 1);
    endfunction

endpackage

// File: rtl/fib_fifo.sv
// Small synchronous FIFO with head data presented on dout.
// Pointers wrap naturally since DEPTH is a power of two.
module fib_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/fib_stream_buf.sv
// Captures Fibonacci terms from the generator into a FIFO and streams them out.
// Tracks the captured term count, first arithmetic wrap and completion.
module fib_stream_buf
    import fib_pkg::*;
#(
    parameter int W       = FIB_W,
    parameter int N_TERMS = FIB_N_TERMS,
    parameter int DEPTH   = 4,
    parameter int CW      = cnt_width(N_TERMS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [W-1:0]  f_i,
    output logic          gen_en_o,
    output logic [W-1:0]  m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] term_cnt_o,
    output logic          ovf_o,
    output logic [CW-1:0] ovf_idx_o,
    output logic          done_o
);

    localparam logic [CW-1:0] N_MAX = CW'(N_TERMS);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          wrap;
    logic [CW-1:0] term_cnt_q, term_cnt_d;
    logic [W-1:0]  prev_q, prev_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] ovf_idx_q, ovf_idx_d;
    logic          done_q, done_d;

    // Enable uses registered full only, so m_ready never reaches gen_en_o.
    assign gen_en_o = ~rst & run & ~full & (term_cnt_q != N_MAX);
    assign push     = gen_en_o;
    assign pop      = m_valid & m_ready;
    assign m_valid  = ~empty;
    assign wrap     = push & (term_cnt_q >= CW'(2)) & (f_i < prev_q);

    fib_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (f_i),
        .dout  (m_data),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        term_cnt_d = term_cnt_q;
        prev_d     = prev_q;
        ovf_d      = ovf_q;
        ovf_idx_d  = ovf_idx_q;
        done_d     = done_q | ((term_cnt_q == N_MAX) & empty);
        if (push) begin
            term_cnt_d = term_cnt_q + CW'(1);
            prev_d     = f_i;
        end
        if (wrap & ~ovf_q) begin
            ovf_d     = 1'b1;
            ovf_idx_d = term_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_cnt_q <= '0;
            prev_q     <= '0;
            ovf_q      <= 1'b0;
            ovf_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            term_cnt_q <= term_cnt_d;
            prev_q     <= prev_d;
            ovf_q      <= ovf_d;
            ovf_idx_q  <= ovf_idx_d;
            done_q     <= done_d;
        end
    end

    assign term_cnt_o = term_cnt_q;
    assign ovf_o      = ovf_q;
    assign ovf_idx_o  = ovf_idx_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_fib_stream_buf.sv
// Directed bench for fib_stream_buf with behavioural generators at W=32 and W=8.
module tb_fib_stream_buf;

    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          m_ready = 1'b0;

    logic [31:0]   f32;
    logic          gen_en32;
    logic [31:0]   m_data32;
    logic          m_valid32;
    logic [CW-1:0] term_cnt32;
    logic          ovf32;
    logic [CW-1:0] ovf_idx32;
    logic          done32;

    logic [7:0]    f8;
    logic          gen_en8;
    logic [7:0]    m_data8;
    logic          m_valid8;
    logic [CW-1:0] term_cnt8;
    logic          ovf8;
    logic [CW-1:0] ovf_idx8;
    logic          done8;

    logic [31:0]   ga32, gb32;
    logic [7:0]    ga8, gb8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fib_stream_buf #(.W(32), .N_TERMS(99), .DEPTH(4), .CW(CW)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .f_i        (f32),
        .gen_en_o   (gen_en32),
        .m_data     (m_data32),
        .m_valid    (m_valid32),
        .m_ready    (m_ready),
        .term_cnt_o (term_cnt32),
        .ovf_o      (ovf32),
        .ovf_idx_o  (ovf_idx32),
        .done_o     (done32)
    );

    fib_stream_buf #(.W(8), .N_TERMS(99), .DEPTH(4), .CW(CW)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .f_i        (f8),
        .gen_en_o   (gen_en8),
        .m_data     (m_data8),
        .m_valid    (m_valid8),
        .m_ready    (m_ready),
        .term_cnt_o (term_cnt8),
        .ovf_o      (ovf8),
        .ovf_idx_o  (ovf_idx8),
        .done_o     (done8)
    );

    // Generator models: f = current term, advance on en.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ga32 <= 32'd0;
            gb32 <= 32'd1;
        end else if (gen_en32) begin
            ga32 <= gb32;
            gb32 <= ga32 + gb32;
        end
    end
    assign f32 = ga32;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ga8 <= 8'd0;
            gb8 <= 8'd1;
        end else if (gen_en8) begin
            ga8 <= gb8;
            gb8 <= ga8 + gb8;
        end
    end
    assign f8 = ga8;

    function automatic logic [31:0] fib32(input int k);
        logic [31:0] a, b, t;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        run = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        run = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        total++;
        if (term_cnt32 !== 0) begin
            bad++; $display("FAIL rst_cnt got=%0d exp=0", term_cnt32);
        end
        total++;
        if (ovf32 !== 1'b0 || ovf_idx32 !== 0) begin
            bad++; $display("FAIL rst_ovf got=%b/%0d exp=0/0", ovf32, ovf_idx32);
        end
        total++;
        if (done32 !== 1'b0) begin
            bad++; $display("FAIL rst_done got=%b exp=0", done32);
        end
        total++;
        if (m_valid32 !== 1'b0 || m_valid8 !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b%b exp=00", m_valid32, m_valid8);
        end
        total++;
        if (gen_en32 !== 1'b0 || gen_en8 !== 1'b0) begin
            bad++; $display("FAIL rst_gen_en got=%b%b exp=00", gen_en32, gen_en8);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] head [8];
        int beats;
        int last_cyc;
        int done_cyc;
        head = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
        beats = 0;
        last_cyc = -10;
        done_cyc = -1;
        apply_reset();
        run = 1'b1;
        m_ready = 1'b1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (m_valid32) begin
                total++;
                if (m_data32 !== fib32(beats)) begin
                    bad++;
                    $display("FAIL free_beat%0d got=%0d exp=%0d", beats, m_data32, fib32(beats));
                end
                if (beats < 8) begin
                    total++;
                    if (m_data32 !== head[beats]) begin
                        bad++;
                        $display("FAIL free_head%0d got=%0d exp=%0d", beats, m_data32, head[beats]);
                    end
                end
                if (beats == 10) begin
                    total++;
                    if (m_data32 !== 32'd55) begin
                        bad++; $display("FAIL free_beat10 got=%0d exp=55", m_data32);
                    end
                end
                if (beats == 47) begin
                    total++;
                    if (m_data32 !== 32'd2971215073 || ovf32 !== 1'b0) begin
                        bad++;
                        $display("FAIL ovf32_b47 got=%0d/%b exp=2971215073/0", m_data32, ovf32);
                    end
                end
                if (beats == 48) begin
                    total++;
                    if (m_data32 !== 32'd512559680 || ovf32 !== 1'b1) begin
                        bad++;
                        $display("FAIL ovf32_b48 got=%0d/%b exp=512559680/1", m_data32, ovf32);
                    end
                end
                if (beats >= 48) begin
                    total++;
                    if (ovf_idx32 !== 7'd48 || ovf32 !== 1'b1) begin
                        bad++;
                        $display("FAIL ovf32_idx beat%0d got=%0d exp=48", beats, ovf_idx32);
                    end
                end
                beats++;
                last_cyc = cyc;
            end
            if (done32) begin
                done_cyc = cyc;
                break;
            end
        end
        total++;
        if (beats != 99) begin
            bad++; $display("FAIL free_beats got=%0d exp=99", beats);
        end
        total++;
        if (done_cyc != last_cyc + 2) begin
            bad++; $display("FAIL free_done_cyc got=%0d exp=%0d", done_cyc, last_cyc + 2);
        end
        total++;
        if (term_cnt32 !== 7'd99) begin
            bad++; $display("FAIL free_cnt got=%0d exp=99", term_cnt32);
        end
        repeat (3) @(negedge clk);
        total++;
        if (gen_en32 !== 1'b0 || m_valid32 !== 1'b0 || done32 !== 1'b1) begin
            bad++;
            $display("FAIL free_after got=en%b v%b d%b exp=en0 v0 d1", gen_en32, m_valid32, done32);
        end
    endtask

    task automatic test_ovf_w8();
        int beats;
        beats = 0;
        apply_reset();
        run = 1'b1;
        m_ready = 1'b1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 40 && beats < 15; cyc++) begin
            @(negedge clk);
            if (m_valid8) begin
                if (beats == 13) begin
                    total++;
                    if (m_data8 !== 8'd233 || ovf8 !== 1'b0) begin
                        bad++; $display("FAIL ovf8_b13 got=%0d/%b exp=233/0", m_data8, ovf8);
                    end
                end
                if (beats == 14) begin
                    total++;
                    if (m_data8 !== 8'd121 || ovf8 !== 1'b1 || ovf_idx8 !== 7'd14) begin
                        bad++;
                        $display("FAIL ovf8_b14 got=%0d/%b/%0d exp=121/1/14", m_data8, ovf8, ovf_idx8);
                    end
                end
                beats++;
            end
        end
        total++;
        if (beats != 15) begin
            bad++; $display("FAIL ovf8_timeout got=%0d exp=15", beats);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [6];
        int beats;
        exp = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5};
        beats = 0;
        apply_reset();
        run = 1'b1;
        m_ready = 1'b0;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (gen_en32 !== 1'b0 || term_cnt32 !== 7'd4) begin
            bad++; $display("FAIL bp_full got=en%b cnt%0d exp=en0 cnt4", gen_en32, term_cnt32);
        end
        total++;
        if (m_valid32 !== 1'b1 || m_data32 !== 32'd0) begin
            bad++; $display("FAIL bp_head got=v%b d%0d exp=v1 d0", m_valid32, m_data32);
        end
        @(negedge clk);
        total++;
        if (m_data32 !== 32'd0 || term_cnt32 !== 7'd4) begin
            bad++; $display("FAIL bp_hold got=d%0d cnt%0d exp=d0 cnt4", m_data32, term_cnt32);
        end
        m_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 30 && beats < 6; cyc++) begin
            if (m_valid32) begin
                total++;
                if (m_data32 !== exp[beats]) begin
                    bad++;
                    $display("FAIL bp_beat%0d got=%0d exp=%0d", beats, m_data32, exp[beats]);
                end
                beats++;
            end
            @(negedge clk);
        end
        total++;
        if (beats != 6) begin
            bad++; $display("FAIL bp_timeout got=%0d exp=6", beats);
        end
    endtask

    task automatic test_run_gap();
        int beats;
        int gap_left;
        bit gapped;
        beats = 0;
        gap_left = 0;
        gapped = 1'b0;
        apply_reset();
        run = 1'b1;
        m_ready = 1'b1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 100 && beats < 22; cyc++) begin
            @(negedge clk);
            if (m_valid32) begin
                total++;
                if (m_data32 !== fib32(beats)) begin
                    bad++;
                    $display("FAIL gap_beat%0d got=%0d exp=%0d", beats, m_data32, fib32(beats));
                end
                if (beats == 20 && m_data32 !== 32'd6765) begin
                    bad++; $display("FAIL gap_b20 got=%0d exp=6765", m_data32);
                end
                if (beats == 21 && m_data32 !== 32'd10946) begin
                    bad++; $display("FAIL gap_b21 got=%0d exp=10946", m_data32);
                end
                beats++;
            end
            if (gap_left > 0) begin
                total++;
                if (gen_en32 !== 1'b0 || term_cnt32 !== 7'd20) begin
                    bad++;
                    $display("FAIL gap_hold got=en%b cnt%0d exp=en0 cnt20", gen_en32, term_cnt32);
                end
                gap_left--;
                if (gap_left == 0) run = 1'b1;
            end else if (!gapped && term_cnt32 == 7'd20) begin
                run = 1'b0;
                #1;
                total++;
                if (gen_en32 !== 1'b0) begin
                    bad++; $display("FAIL gap_drop got=%b exp=0", gen_en32);
                end
                gapped = 1'b1;
                gap_left = 5;
            end
        end
        total++;
        if (beats != 22 || !gapped) begin
            bad++; $display("FAIL gap_timeout got=%0d exp=22", beats);
        end
    endtask

    task automatic test_async_rst();
        bit hit;
        int beats;
        hit = 1'b0;
        beats = 0;
        apply_reset();
        run = 1'b1;
        m_ready = 1'b1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (term_cnt32 == 7'd30) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit || m_valid32 !== 1'b1) begin
            bad++; $display("FAIL arst_pre got=hit%b v%b exp=hit1 v1", hit, m_valid32);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (term_cnt32 !== 0 || m_valid32 !== 1'b0 || gen_en32 !== 1'b0) begin
            bad++;
            $display("FAIL arst_out got=cnt%0d v%b en%b exp=0 0 0", term_cnt32, m_valid32, gen_en32);
        end
        total++;
        if (ovf32 !== 1'b0 || ovf_idx32 !== 0 || done32 !== 1'b0) begin
            bad++; $display("FAIL arst_flags got=%b/%0d/%b exp=0/0/0", ovf32, ovf_idx32, done32);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 10 && beats < 2; cyc++) begin
            @(negedge clk);
            if (m_valid32) begin
                total++;
                if (m_data32 !== fib32(beats)) begin
                    bad++;
                    $display("FAIL arst_beat%0d got=%0d exp=%0d", beats, m_data32, fib32(beats));
                end
                beats++;
            end
        end
        total++;
        if (beats != 2) begin
            bad++; $display("FAIL arst_timeout got=%0d exp=2", beats);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ovf_w8();
        test_backpressure();
        test_run_gap();
        test_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_stream_buf.md
Name: fib_stream_buf

Overview:
- Downstream consumer of the Fibonacci term generator (ports clk, rst, en, f[W]).
- Drives the generator's en and captures one term per enabled cycle into a small FIFO.
- Presents the captured terms on a valid/ready master stream.
- Counts captured terms and flags W-bit arithmetic wrap-around (overflow) of the sequence.

Parameters:
- W, 32, data width of f_i and m_data; must match the generator's W.
- N_TERMS, 99, number of terms to capture; matches the generator's internal term limit.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CW, $clog2(N_TERMS+1), width of the term counter and overflow index.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset; shared with the generator
- run  in  1  level enable; capture proceeds only while high
- f_i  in  W  generator output f
- gen_en_o  out  1  drives the generator's en
- m_data  out  W  head-of-FIFO term
- m_valid  out  1  m_data is valid
- m_ready  in  1  consumer accepts m_data
- term_cnt_o  out  CW  number of terms captured so far
- ovf_o  out  1  sticky overflow flag
- ovf_idx_o  out  CW  index of the first wrapped term
- done_o  out  1  all N_TERMS captured and FIFO drained

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied.
  - term_cnt_o=0, ovf_o=0, ovf_idx_o=0, done_o=0, m_valid=0, gen_en_o=0.
  - Previous-term register = 0.
- Enable, combinational: gen_en_o = run & ~full & (term_cnt_o != N_TERMS). No combinational path from m_ready.
- Push:
  - On each rising edge with gen_en_o=1, f_i is written to the FIFO tail and term_cnt_o increments.
  - The generator advances on the same edge.
  - Captured sequence is 0,1,1,2,3,5,...; term index k (0-based) = F(k).
- Latency: a term pushed at edge t is visible on m_data with m_valid=1 after edge t, if the FIFO was empty.
- Pop:
  - On an edge with m_valid & m_ready, the head entry is removed.
  - m_data is stable while m_valid=1 and m_ready=0.
- Boundaries:
  - Full: no push, even if a pop occurs in the same cycle, because gen_en_o depends only on registered full. This costs one bubble and is accepted.
  - Empty: m_valid=0; m_ready is ignored.
  - Simultaneous push and pop when not full: both happen; occupancy is unchanged.
  - term_cnt_o saturates at N_TERMS; gen_en_o stays 0 afterwards.
- Overflow:
  - For a push at index k ≥ 2, if f_i < the previous pushed term (unsigned compare), the term has wrapped.
  - On the first wrap, ovf_o is set and ovf_idx_o = k. Later wraps do not change ovf_idx_o.
  - ovf_o is cleared only by rst.
  - Wrapped terms are still pushed unmodified.
- done_o: registered; set when term_cnt_o == N_TERMS and the FIFO is empty; held until rst.
- run deassert mid-stream: gen_en_o drops the same cycle and the generator freezes. The FIFO keeps draining. Capture resumes with no lost or duplicated term.
- Restart: the generator cannot restart without rst, so this block has no soft restart. rst mid-operation returns both blocks to term 0.

Decomposition:
- Shared package, fib_pkg:
  - W default
  - N_TERMS default
  - CW derivation
- Sub-module fib_fifo:
  - Synchronous FIFO, parameters W and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-high reset; registered read pointer with head data on dout.
- Top level holds: term counter, enable logic, overflow compare/previous-term register, done register.

Test Plan:
- Free run (W=32, m_ready=1, run=1 after reset): m_data beats 0,1,1,2,3,5,8,13; beat 10 = 55; exactly 99 beats; term_cnt_o=99; done_o=1 one cycle after the last pop; gen_en_o=0 thereafter.
- Backpressure (m_ready=0, DEPTH=4): gen_en_o falls after 4 pushes, term_cnt_o=4, m_data=0 held. Raise m_ready: the beat stream continues 0,1,1,2,3,5 with no gap in values and no duplicates.
- Overflow W=32: beat 47 = 2971215073, ovf_o=0; beat 48 = 512559680, ovf_o=1, ovf_idx_o=48; ovf_idx_o unchanged through beat 98.
- Overflow W=8: beat 13 = 233; beat 14 = 121, ovf_o=1, ovf_idx_o=14.
- run toggled low for 5 cycles at term 20: gen_en_o=0 during the gap; beats 20,21 = 6765,10946 are contiguous.
- rst asserted at term 30 with FIFO non-empty: all outputs return to reset values asynchronously. After release with run=1, the first beat is 0.
